vector_mac_accel_mlane: RTL

//  Second-generation Wishbone-mapped vector MAC / 1D-convolution / elementwise-multiply engine. LANES

---
 rtl/vector_mac_accel_mlane.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/vector_mac_accel_mlane.sv
// Wishbone-mapped vector MAC engine: dot product, 1D convolution and elementwise multiply, LANES MACs/cycle.
// Optional build macro VMAC_SATURATE_EN: saturate OUT writes to DATA_WIDTH and flag STATUS.sat.

module vector_mac_accel_mlane_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64
) (
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_b,
    input  logic        [5:0]            i_shift,
    input  logic                         i_vld,
    output logic        [ACC_WIDTH-1:0]  o_p
);
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [2*DATA_WIDTH-1:0] w_sh;

    assign w_prod = i_a * i_b;
    assign w_sh   = w_prod >>> i_shift;
    assign o_p    = i_vld ? ACC_WIDTH'(w_sh) : '0;
endmodule

module vector_mac_accel_mlane #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LEN    = 4096,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [ADDR_WIDTH-1:0]   wb_adr,
    input  logic [DATA_WIDTH-1:0]   wb_dat_w,
    output logic [DATA_WIDTH-1:0]   wb_dat_r,
    output logic                    wb_ack,
    output logic                    irq
);
    localparam int IW = $clog2(MAX_LEN);
    localparam logic [1:0] M_DOT = 2'd0, M_CONV = 2'd1, M_ELEM = 2'd2, M_RSVD = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB, S_DONE} state_t;
    state_t r_state, w_state_nx;

    logic                  r_ack, r_irq_en, r_err;
    logic [1:0]            r_mode_reg, r_mode;
    logic [31:0]           r_len_reg, r_klen_reg, r_len, r_klen;
    logic [5:0]            r_shift_reg, r_shift;
    logic [31:0]           r_idx, r_o, r_k;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [63:0]           r_cyc, r_cyc_lat;

    logic [DATA_WIDTH-1:0] r_mem_a   [MAX_LEN];
    logic [DATA_WIDTH-1:0] r_mem_b   [MAX_LEN];
    logic [DATA_WIDTH-1:0] r_mem_out [MAX_LEN];

    logic [ADDR_WIDTH-13:0] w_region;
    logic [11:0]            w_off;
    logic                   w_in_bank, w_reg_sel, w_req, w_wr, w_busy;
    logic                   w_ctrl_wr, w_clear, w_start, w_perr;
    logic [1:0]             w_new_mode;
    logic [32:0]            w_span;
    logic                   w_mac_last, w_out_last, w_sat;
    logic                   w_unused;

    logic [LANES-1:0][DATA_WIDTH-1:0] w_a, w_b, w_el_val;
    logic [LANES-1:0][ACC_WIDTH-1:0]  w_p;
    logic [LANES-1:0][IW-1:0]         w_ai_ix;
    logic [LANES-1:0]                 w_vld;
    logic [ACC_WIDTH-1:0]             w_sum;
    logic [DATA_WIDTH-1:0]            w_wb_val;

    assign w_unused  = &{1'b0, wb_sel};
    assign w_region  = wb_adr[ADDR_WIDTH-1:12];
    assign w_off     = wb_adr[11:0];
    assign w_in_bank = 32'(w_off) < 32'(MAX_LEN);
    assign w_reg_sel = (w_region == '0) && (wb_adr[11:3] == '0);
    assign w_req     = wb_cyc & wb_stb & ~r_ack;
    assign w_wr      = w_req & wb_we;
    assign w_busy    = (r_state == S_RUN) || (r_state == S_WB);
    assign w_ctrl_wr = w_wr && w_reg_sel && (wb_adr[2:0] == 3'd0);
    assign w_clear   = w_ctrl_wr & wb_dat_w[1];
    assign w_start   = w_ctrl_wr & wb_dat_w[0] & ~wb_dat_w[1] & (r_state == S_IDLE);
    assign w_new_mode = wb_dat_w[3:2];

    // Parameters are validated against the register values at the moment start is written.
    assign w_span = 33'(r_len_reg) + 33'(r_klen_reg) - 33'd1;
    assign w_perr = (r_len_reg == '0) || (w_new_mode == M_RSVD) ||
                    ((w_new_mode != M_CONV) && (r_len_reg > 32'(MAX_LEN))) ||
                    ((w_new_mode == M_CONV) && ((r_klen_reg == '0) || (w_span > 33'(MAX_LEN))));

    assign w_mac_last = (r_mode == M_CONV) ? (33'(r_k) + 33'(LANES) >= 33'(r_klen))
                                           : (33'(r_idx) + 33'(LANES) >= 33'(r_len));
    assign w_out_last = (33'(r_o) + 33'd1 >= 33'(r_len));

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            logic [31:0] w_ai, w_bi;
            always_comb begin
                if (r_mode == M_CONV) begin
                    w_bi = r_k + 32'(l);
                    w_ai = r_o + w_bi;
                    w_vld[l] = w_bi < r_klen;
                end else begin
                    w_ai = r_idx + 32'(l);
                    w_bi = w_ai;
                    w_vld[l] = w_ai < r_len;
                end
            end
            assign w_ai_ix[l] = w_ai[IW-1:0];
            assign w_a[l]     = r_mem_a[w_ai[IW-1:0]];
            assign w_b[l]     = r_mem_b[w_bi[IW-1:0]];

            vector_mac_accel_mlane_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
                .i_a(w_a[l]), .i_b(w_b[l]), .i_shift(r_shift), .i_vld(w_vld[l]), .o_p(w_p[l])
            );
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) w_sum = w_sum + w_p[i];
    end

`ifdef VMAC_SATURATE_EN
    logic r_sat, w_sat_evt;

    function automatic logic f_ovf(input logic [ACC_WIDTH-1:0] v);
        return !((&v[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|v[ACC_WIDTH-1:DATA_WIDTH-1]));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_narrow(input logic [ACC_WIDTH-1:0] v);
        if (f_ovf(v)) return v[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return v[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        w_wb_val  = f_narrow(r_acc);
        w_sat_evt = (r_state == S_WB) && f_ovf(r_acc);
        for (int i = 0; i < LANES; i++) begin
            w_el_val[i] = f_narrow(w_p[i]);
            if ((r_state == S_RUN) && (r_mode == M_ELEM) && w_vld[i] && f_ovf(w_p[i])) w_sat_evt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_sat <= 1'b0;
        else if (w_clear)       r_sat <= 1'b0;
        else if (w_sat_evt)     r_sat <= 1'b1;
    end
    assign w_sat = r_sat;
`else
    always_comb begin
        w_wb_val = r_acc[DATA_WIDTH-1:0];
        for (int i = 0; i < LANES; i++) w_el_val[i] = w_p[i][DATA_WIDTH-1:0];
    end
    assign w_sat = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_state_nx = w_perr ? S_DONE : S_RUN;
            S_RUN:  if (w_mac_last) w_state_nx = (r_mode == M_ELEM) ? S_DONE : S_WB;
            S_WB:   w_state_nx = ((r_mode == M_CONV) && !w_out_last) ? S_RUN : S_DONE;
            S_DONE: w_state_nx = S_DONE;
            default: w_state_nx = S_IDLE;
        endcase
        if (w_clear) w_state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0; r_irq_en <= 1'b0; r_err <= 1'b0;
            r_mode_reg <= '0; r_mode <= '0;
            r_len_reg <= '0; r_klen_reg <= '0; r_len <= '0; r_klen <= '0;
            r_shift_reg <= 6'd15; r_shift <= '0;
            r_idx <= '0; r_o <= '0; r_k <= '0; r_acc <= '0;
            r_cyc <= '0; r_cyc_lat <= '0;
        end else begin
            r_ack <= w_req;
            if (w_wr && w_reg_sel) begin
                case (wb_adr[2:0])
                    3'd0: begin r_mode_reg <= wb_dat_w[3:2]; r_irq_en <= wb_dat_w[4]; end
                    3'd2: if (!w_busy) r_len_reg   <= 32'(wb_dat_w);
                    3'd3: if (!w_busy) r_klen_reg  <= 32'(wb_dat_w);
                    3'd6: if (!w_busy) r_shift_reg <= wb_dat_w[5:0];
                    default: ;
                endcase
            end
            if (w_clear) begin
                r_err <= 1'b0; r_cyc <= '0; r_cyc_lat <= '0; r_acc <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_start) begin
                        r_mode <= w_new_mode; r_len <= r_len_reg; r_klen <= r_klen_reg; r_shift <= r_shift_reg;
                        r_idx <= '0; r_o <= '0; r_k <= '0; r_acc <= '0; r_cyc <= '0;
                        r_err <= w_perr;
                    end
                    S_RUN: begin
                        r_cyc <= r_cyc + 64'd1;
                        if (r_mode != M_ELEM) r_acc <= r_acc + w_sum;
                        r_idx <= r_idx + 32'(LANES);
                        r_k   <= r_k + 32'(LANES);
                        if (w_state_nx == S_DONE) r_cyc_lat <= r_cyc + 64'd1;
                    end
                    S_WB: begin
                        r_cyc <= r_cyc + 64'd1;
                        r_o   <= r_o + 32'd1;
                        r_k   <= '0;
                        r_acc <= '0;
                        if (w_state_nx == S_DONE) r_cyc_lat <= r_cyc + 64'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Banks are not reset; bus writes only land while the engine is idle, so no write port collides.
    always_ff @(posedge clk) begin
        if (w_wr && !w_busy && w_in_bank) begin
            case (w_region)
                (ADDR_WIDTH-12)'(1): r_mem_a[w_off[IW-1:0]]   <= wb_dat_w;
                (ADDR_WIDTH-12)'(2): r_mem_b[w_off[IW-1:0]]   <= wb_dat_w;
                (ADDR_WIDTH-12)'(3): r_mem_out[w_off[IW-1:0]] <= wb_dat_w;
                default: ;
            endcase
        end
        if (r_state == S_WB) r_mem_out[r_o[IW-1:0]] <= w_wb_val;
        if ((r_state == S_RUN) && (r_mode == M_ELEM)) begin
            for (int i = 0; i < LANES; i++)
                if (w_vld[i]) r_mem_out[w_ai_ix[i]] <= w_el_val[i];
        end
    end

    always_comb begin
        wb_dat_r = '0;
        if (w_reg_sel) begin
            case (wb_adr[2:0])
                3'd0: wb_dat_r = DATA_WIDTH'({r_irq_en, r_mode_reg, 2'b00});
                3'd1: wb_dat_r = DATA_WIDTH'({w_sat, r_err, (r_state == S_DONE), w_busy});
                3'd2: wb_dat_r = DATA_WIDTH'(r_len_reg);
                3'd3: wb_dat_r = DATA_WIDTH'(r_klen_reg);
                3'd4: wb_dat_r = DATA_WIDTH'(r_cyc_lat[31:0]);
                3'd5: wb_dat_r = DATA_WIDTH'(r_cyc_lat[63:32]);
                3'd6: wb_dat_r = DATA_WIDTH'(r_shift_reg);
                default: wb_dat_r = DATA_WIDTH'(32'h0002_0000 | 32'(LANES));
            endcase
        end else if (w_in_bank) begin
            case (w_region)
                (ADDR_WIDTH-12)'(1): wb_dat_r = r_mem_a[w_off[IW-1:0]];
                (ADDR_WIDTH-12)'(2): wb_dat_r = r_mem_b[w_off[IW-1:0]];
                (ADDR_WIDTH-12)'(3): wb_dat_r = r_mem_out[w_off[IW-1:0]];
                default: ;
            endcase
        end
    end

    assign wb_ack = r_ack;
    assign irq    = (r_state == S_DONE) & r_irq_en;
endmodule
